pulse_channel_gen: RTL and testbench

Parametrised successor to the fixed-duty pulse channel. It provides a phase-accumulator pulse voice with:
- selectable duty cycle
- note-triggered volume envelope with linear decay
- length counter that gates the note off
- an activity flag
A note sequencer drives the note parameters and strobes into it, and its output feeds the mixer/PWM stage.

---
 rtl/pulse_channel_gen.sv | 173 +++++++++++++++++
 tb/tb_pulse_channel_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_channel_gen.sv
// Phase-accumulator pulse voice: duty select, linear-decay envelope, length gate.
// One clock from phase register to o_output; no backpressure. Optional sweep: PULSE_CHANNEL_SWEEP_EN.
module pulse_channel_gen #(
    parameter int PHASE_WIDTH = 32,
    parameter int OUT_WIDTH   = 9,
    parameter int TIMER_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_tick_stb,
    input  logic                   i_note_stb,
    input  logic [PHASE_WIDTH-1:0] i_phase_delta,
    input  logic [1:0]             i_duty,
    input  logic [OUT_WIDTH-1:0]   i_volume,
    input  logic [TIMER_WIDTH-1:0] i_decay_period,
    input  logic [TIMER_WIDTH-1:0] i_length,
`ifdef PULSE_CHANNEL_SWEEP_EN
    input  logic [3:0]             i_sweep,
`endif
    output logic [OUT_WIDTH-1:0]   o_output,
    output logic                   o_frame_pulse,
    output logic                   o_active
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [PHASE_WIDTH-1:0] delta_q, delta_d;
    logic [1:0]             duty_q, duty_d;
    logic [OUT_WIDTH-1:0]   env_q, env_d;
    logic [OUT_WIDTH-1:0]   out_q, out_d;
    logic [TIMER_WIDTH-1:0] decay_per_q, decay_per_d;
    logic [TIMER_WIDTH-1:0] decay_cnt_q, decay_cnt_d;
    logic [TIMER_WIDTH-1:0] len_q, len_d;
    logic [TIMER_WIDTH-1:0] len_cnt_q, len_cnt_d;

    logic [2:0]             phase_top;
    logic                   wave_high;
    logic                   note_end;

`ifdef PULSE_CHANNEL_SWEEP_EN
    logic [3:0]             sweep_q, sweep_d;
    logic [PHASE_WIDTH-1:0] delta_shr;
    logic [PHASE_WIDTH:0]   sweep_sum;
    logic [PHASE_WIDTH-1:0] sweep_diff;

    always_comb begin
        delta_shr  = delta_q >> sweep_q[2:0];
        sweep_sum  = {1'b0, delta_q} + {1'b0, delta_shr};
        sweep_diff = delta_q - delta_shr;
    end
`endif

    // Top three phase bits select the eighth of the period we are in.
    always_comb begin
        phase_top = phase_q[PHASE_WIDTH-1 -: 3];
        wave_high = 1'b0;
        case (duty_q)
            2'd0:    wave_high = (phase_top < 3'd1);
            2'd1:    wave_high = (phase_top < 3'd2);
            2'd2:    wave_high = (phase_top < 3'd4);
            default: wave_high = (phase_top < 3'd6);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        delta_d     = delta_q;
        duty_d      = duty_q;
        env_d       = env_q;
        decay_per_d = decay_per_q;
        decay_cnt_d = decay_cnt_q;
        len_d       = len_q;
        len_cnt_d   = len_cnt_q;
        note_end    = 1'b0;
`ifdef PULSE_CHANNEL_SWEEP_EN
        sweep_d     = sweep_q;
`endif
        out_d = (state_q == S_ACTIVE && wave_high) ? env_q : '0;

        if (i_note_stb) begin
            state_d     = S_ACTIVE;
            phase_d     = '0;
            delta_d     = i_phase_delta;
            duty_d      = i_duty;
            env_d       = i_volume;
            decay_per_d = i_decay_period;
            decay_cnt_d = '0;
            len_d       = i_length;
            len_cnt_d   = i_length;
`ifdef PULSE_CHANNEL_SWEEP_EN
            sweep_d     = i_sweep;
`endif
        end else if (state_q == S_ACTIVE) begin
            phase_d = phase_q + delta_q;
            if (i_tick_stb) begin
                if (decay_per_q != '0) begin
                    if (decay_cnt_q == decay_per_q - TIMER_WIDTH'(1)) begin
                        decay_cnt_d = '0;
                        if (env_q != '0)
                            env_d = env_q - OUT_WIDTH'(1);
                    end else begin
                        decay_cnt_d = decay_cnt_q + TIMER_WIDTH'(1);
                    end
                end
                if (len_q != '0) begin
                    len_cnt_d = len_cnt_q - TIMER_WIDTH'(1);
                    if (len_cnt_q == TIMER_WIDTH'(1))
                        note_end = 1'b1;
                end
`ifdef PULSE_CHANNEL_SWEEP_EN
                // An up-sweep past full scale kills the note and keeps the old delta.
                if (sweep_q[2:0] != 3'd0) begin
                    if (sweep_q[3])
                        delta_d = sweep_diff;
                    else if (sweep_sum[PHASE_WIDTH])
                        note_end = 1'b1;
                    else
                        delta_d = sweep_sum[PHASE_WIDTH-1:0];
                end
`endif
            end
            if (note_end) begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        end else begin
            phase_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            delta_q     <= '0;
            duty_q      <= '0;
            env_q       <= '0;
            out_q       <= '0;
            decay_per_q <= '0;
            decay_cnt_q <= '0;
            len_q       <= '0;
            len_cnt_q   <= '0;
`ifdef PULSE_CHANNEL_SWEEP_EN
            sweep_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            delta_q     <= delta_d;
            duty_q      <= duty_d;
            env_q       <= env_d;
            out_q       <= out_d;
            decay_per_q <= decay_per_d;
            decay_cnt_q <= decay_cnt_d;
            len_q       <= len_d;
            len_cnt_q   <= len_cnt_d;
`ifdef PULSE_CHANNEL_SWEEP_EN
            sweep_q     <= sweep_d;
`endif
        end
    end

    assign o_output      = out_q;
    assign o_frame_pulse = phase_q[PHASE_WIDTH-1];
    assign o_active      = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_pulse_channel_gen.sv
// Bench for pulse_channel_gen: vector table, hand sequences, random run against a closed-form model.
module tb_pulse_channel_gen;
    localparam int PW = 32;
    localparam int OW = 9;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick_stb = 1'b0;
    logic          note_stb = 1'b0;
    logic [PW-1:0] delta = '0;
    logic [1:0]    duty = '0;
    logic [OW-1:0] vol = '0;
    logic [TW-1:0] per = '0;
    logic [TW-1:0] len = '0;
    logic [OW-1:0] dut_out;
    logic          dut_fp;
    logic          dut_act;

    always #5 clk = ~clk;

    pulse_channel_gen #(.PHASE_WIDTH(PW), .OUT_WIDTH(OW), .TIMER_WIDTH(TW)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_tick_stb(tick_stb),
        .i_note_stb(note_stb),
        .i_phase_delta(delta),
        .i_duty(duty),
        .i_volume(vol),
        .i_decay_period(per),
        .i_length(len),
`ifdef PULSE_CHANNEL_SWEEP_EN
        .i_sweep(4'b0000),
`endif
        .o_output(dut_out),
        .o_frame_pulse(dut_fp),
        .o_active(dut_act)
    );

    int n_vec = 0;
    int n_mis = 0;

    // Reference: a note is described by clocks elapsed and ticks seen since its strobe.
    bit            m_act = 1'b0;
    int            m_n = 0;
    int            m_ticks = 0;
    logic [PW-1:0] m_delta = '0;
    int            m_duty = 0;
    int            m_vol = 0;
    int            m_per = 0;
    int            m_len = 0;
    int            m_out = 0;

    function automatic logic [PW-1:0] m_phase();
        longint p;
        p = longint'(m_n) * longint'(m_delta);
        return p[PW-1:0];
    endfunction

    function automatic int m_env();
        if (m_per == 0) return m_vol;
        if (m_ticks / m_per >= m_vol) return 0;
        return m_vol - m_ticks / m_per;
    endfunction

    function automatic bit m_high();
        longint ph;
        longint full;
        full = 64'd1 << PW;
        ph = longint'(m_phase());
        case (m_duty)
            0:       return ph < full / 8;
            1:       return ph < full / 4;
            2:       return ph < full / 2;
            default: return ph < (full / 4) * 3;
        endcase
    endfunction

    function automatic logic [OW+1:0] m_expect();
        logic [PW-1:0] ph;
        ph = m_phase();
        return {OW'(m_out), m_act ? ph[PW-1] : 1'b0, m_act};
    endfunction

    task automatic apply(input bit r, input bit n, input bit t);
        int nout;
        rst = r;
        note_stb = n;
        tick_stb = t;
        if (r) begin
            m_act = 0; m_n = 0; m_ticks = 0; m_delta = '0;
            m_duty = 0; m_vol = 0; m_per = 0; m_len = 0; m_out = 0;
        end else begin
            nout = (m_act && m_high()) ? m_env() : 0;
            if (n) begin
                m_act = 1; m_n = 0; m_ticks = 0; m_delta = delta;
                m_duty = int'(duty); m_vol = int'(vol); m_per = int'(per); m_len = int'(len);
            end else if (m_act) begin
                m_n++;
                if (t) begin
                    m_ticks++;
                    if (m_len != 0 && m_ticks == m_len) m_act = 0;
                end
            end
            m_out = nout;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        note_stb = 1'b0;
        tick_stb = 1'b0;
    endtask

    task automatic check(input string name, input logic [OW+1:0] exp);
        logic [OW+1:0] got;
        got = {dut_out, dut_fp, dut_act};
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got out=%0d fp=%0b act=%0b, expected out=%0d fp=%0b act=%0b",
                     name, got[OW+1:2], got[1], got[0], exp[OW+1:2], exp[1], exp[0]);
        end
    endtask

    typedef struct {
        bit         r;
        bit         n;
        bit         t;
        logic [1:0] d;
        int         o;
        bit         f;
        bit         a;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit n, bit t, logic [1:0] d, int o, bit f, bit a);
        vec_t v;
        v.r = r; v.n = n; v.t = t; v.d = d; v.o = o; v.f = f; v.a = a;
        return v;
    endfunction

    initial begin
        int dutys[4] = '{2, 0, 1, 3};
        int runs[4]  = '{8, 2, 4, 12};
        int dec_exp[10] = '{3, 2, 2, 1, 1, 0, 0, 0, 0, 0};

        // Reset, 100 idle clocks, then a 16-clock note per duty setting.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 100; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(0, 1, 0, 2'(dutys[k]), (k == 0) ? 0 : 100, 0, 1));
            for (int j = 1; j <= 16; j++)
                tbl.push_back(mk(0, 0, 0, 2'(dutys[k]), (j - 1 < runs[k]) ? 100 : 0,
                                 (j % 16) >= 8, 1));
        end
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));

        delta = PW'(64'd1 << (PW - 4));
        vol = 9'd100; per = '0; len = '0;
        foreach (tbl[i]) begin
            duty = tbl[i].d;
            apply(tbl[i].r, tbl[i].n, tbl[i].t);
            check($sformatf("table[%0d]", i), {OW'(tbl[i].o), tbl[i].f, tbl[i].a});
        end

        // Decay: period 2 from volume 3, delta 0 keeps the wave permanently high.
        delta = '0; duty = 2'd0; vol = 9'd3; per = 8'd2; len = '0;
        apply(0, 1, 0);
        apply(0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            apply(0, 0, 1);
            apply(0, 0, 0);
            check($sformatf("decay_tick%0d", k + 1), {OW'(dec_exp[k]), 1'b0, 1'b1});
        end

        // Length 5 expiry.
        vol = 9'd7; per = '0; len = 8'd5;
        apply(0, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            apply(0, 0, 1);
            check($sformatf("len_tick%0d", k), {OW'(7), 1'b0, k < 5});
        end
        apply(0, 0, 0);
        check("len_after_expire", {OW'(0), 1'b0, 1'b0});

        // Retrigger on tick 3 together with a tick: reload, tick ignored.
        apply(0, 1, 0);
        apply(0, 0, 1);
        apply(0, 0, 1);
        apply(0, 1, 1);
        check("retrig_edge", {OW'(7), 1'b0, 1'b1});
        for (int k = 1; k <= 5; k++) begin
            apply(0, 0, 1);
            check($sformatf("retrig_tick%0d", k), {OW'(7), 1'b0, k < 5});
        end
        apply(0, 0, 0);
        check("retrig_after_expire", {OW'(0), 1'b0, 1'b0});

        // Reset mid-note with both strobes high.
        delta = PW'(64'd1 << (PW - 4)); len = '0;
        apply(0, 1, 0);
        apply(0, 0, 0);
        apply(0, 0, 0);
        check("pre_reset_active", {OW'(7), 1'b0, 1'b1});
        apply(1, 1, 1);
        check("reset_mid_note", {OW'(0), 1'b0, 1'b0});
        apply(0, 0, 0);
        check("reset_strobes_ignored", {OW'(0), 1'b0, 1'b0});

        // Randomised traffic against the reference model.
        for (int c = 0; c < 4000; c++) begin
            delta = $urandom >> $urandom_range(0, 8);
            duty  = 2'($urandom);
            vol   = ($urandom_range(0, 1) == 0) ? OW'($urandom_range(0, 12)) : OW'($urandom);
            per   = TW'($urandom_range(0, 3));
            len   = TW'($urandom_range(0, 10));
            apply($urandom_range(0, 499) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 2) == 0);
            check($sformatf("random[%0d]", c), m_expect());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
